// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encoding and default widths for the register write arbiter
package reg_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;

  // 2'd3 is never entered; the next-state decode sends it back to idle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/reg4_load.sv
// rtl/reg4_load.sv - register with synchronous reset and load enable
module reg4_load #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_out <= '0;
    end else if (load) begin
      q_out <= d_in;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first asserted req at or after rr_ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_valid
);

  // Scan from the farthest offset down so the nearest asserted request wins last
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        win_id    = ID_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sequencing writes into one load-enabled register
// Optional read-back check enabled by REG_WRITE_ARB_READBACK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      reg_load,
  output logic [DATA_W-1:0]         reg_d,
  input  logic [DATA_W-1:0]         reg_q,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      chk_err
);

  arb_state_t        state, state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;
  logic [DATA_W-1:0] data_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = win_valid ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted write never pulses load or ack
  always_comb begin
    ack      = '0;
    reg_load = 1'b0;
    busy     = 1'b0;
    reg_d    = reset ? '0 : data_q;
    if (!reset) begin
      case (state)
        ST_LOAD: begin
          reg_load = 1'b1;
          busy     = 1'b1;
        end
        ST_ACK: begin
          ack  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      if (state == ST_IDLE && win_valid) begin
        grant_q <= win_id;
        data_q  <= wdata[int'(win_id)*DATA_W +: DATA_W];
      end
      if (state == ST_ACK) begin
        rr_ptr <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign grant_id = grant_q;

`ifdef REG_WRITE_ARB_READBACK_EN
  logic chk_err_q;

  // The register loaded on the previous edge, so q_out is settled during ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_err_q <= 1'b0;
    end else if (state == ST_ACK && reg_q != data_q) begin
      chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign chk_err      = 1'b0;
`endif

endmodule
